// File: rtl/life_manager.sv
// -----------------------------------------------------------------------------
// life_manager
//   Owns the player's life count and the post-hit invulnerability window.
//   It feeds the 2-bit lives value to the HUD life-icon bitmap, a blink flag
//   to the ship sprite, a one-cycle FX pulse when a hit is accepted and the
//   game-over flag to the game controller.
//
// Parameters
//   INIT_LIVES     lives loaded at reset and on newGame (1..3)
//   MAX_LIVES      saturation ceiling for extraLife (INIT_LIVES..3)
//   INVULN_FRAMES  frames of invulnerability after a non-fatal hit (1..255)
//   BLINK_SHIFT    frame-counter bit that drives blinkOff (0..7)
//
// Ports
//   clk            in   system clock
//   resetN         in   asynchronous active-low reset
//   startOfFrame   in   one-cycle pulse per VGA frame
//   playerHit      in   one-cycle pulse: ship collided with enemy/enemy shot
//   extraLife      in   one-cycle pulse: award one life
//   newGame        in   one-cycle pulse: restart game
//   lives          out  current life count (0..3)
//   invulnerable   out  high while hits are ignored
//   blinkOff       out  high = suppress the ship sprite this frame
//   lifeLostPulse  out  one-cycle pulse when a hit is accepted
//   gameOver       out  high once lives reach 0, until newGame
//
// All outputs come straight from flops, so every event shows up on the
// outputs one clock after the cycle in which it was sampled.
// -----------------------------------------------------------------------------
module life_manager #(
  parameter logic [1:0] INIT_LIVES    = 2'd3,
  parameter logic [1:0] MAX_LIVES     = 2'd3,
  parameter logic [7:0] INVULN_FRAMES = 8'd120,
  parameter int         BLINK_SHIFT   = 3
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       playerHit,
  input  logic       extraLife,
  input  logic       newGame,
  output logic [1:0] lives,
  output logic       invulnerable,
  output logic       blinkOff,
  output logic       lifeLostPulse,
  output logic       gameOver
);

  typedef enum logic [1:0] {
    ST_ALIVE     = 2'd0,
    ST_INVULN    = 2'd1,
    ST_GAME_OVER = 2'd2
  } state_t;

  state_t     state_q,         state_d;
  logic [1:0] lives_q,         lives_d;
  logic [7:0] frame_cnt_q,     frame_cnt_d;
  logic       invulnerable_q,  invulnerable_d;
  logic       blink_off_q,     blink_off_d;
  logic       life_lost_q,     life_lost_d;
  logic       game_over_q,     game_over_d;

  // Saturating increment: an extra life never pushes the count past MAX_LIVES.
  function automatic logic [1:0] sat_inc(input logic [1:0] cur);
    if (cur < MAX_LIVES) begin
      sat_inc = cur + 2'd1;
    end else begin
      sat_inc = cur;
    end
  endfunction

  // Next-state computation; priority is newGame > playerHit > extraLife > frame counting.
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    frame_cnt_d = frame_cnt_q;
    life_lost_d = 1'b0;

    if (newGame) begin
      state_d     = ST_ALIVE;
      lives_d     = INIT_LIVES;
      frame_cnt_d = 8'd0;
    end else begin
      case (state_q)
        ST_ALIVE: begin
          if (playerHit) begin
            // Any extraLife arriving with the hit is intentionally dropped.
            life_lost_d = 1'b1;
            if (lives_q <= 2'd1) begin
              state_d     = ST_GAME_OVER;
              lives_d     = 2'd0;
              frame_cnt_d = 8'd0;
            end else begin
              // Counter is loaded, not decremented, even if a frame starts now.
              state_d     = ST_INVULN;
              lives_d     = lives_q - 2'd1;
              frame_cnt_d = INVULN_FRAMES;
            end
          end else if (extraLife) begin
            lives_d = sat_inc(lives_q);
          end else begin
            lives_d = lives_q;
          end
        end

        ST_INVULN: begin
          // Hits are ignored here; extraLife and frame counting may coincide.
          if (extraLife) begin
            lives_d = sat_inc(lives_q);
          end else begin
            lives_d = lives_q;
          end
          if (startOfFrame) begin
            if (frame_cnt_q <= 8'd1) begin
              state_d     = ST_ALIVE;
              frame_cnt_d = 8'd0;
            end else begin
              frame_cnt_d = frame_cnt_q - 8'd1;
            end
          end else begin
            frame_cnt_d = frame_cnt_q;
          end
        end

        ST_GAME_OVER: begin
          // Only newGame leaves this state.
          lives_d     = 2'd0;
          frame_cnt_d = 8'd0;
        end

        default: begin
          // Unreachable encoding: recover to a safe, playable state.
          state_d     = ST_ALIVE;
          lives_d     = INIT_LIVES;
          frame_cnt_d = 8'd0;
        end
      endcase
    end

    invulnerable_d = (state_d == ST_INVULN);
    game_over_d    = (state_d == ST_GAME_OVER);
    if (state_d == ST_INVULN) begin
      blink_off_d = frame_cnt_d[BLINK_SHIFT];
    end else begin
      blink_off_d = 1'b0;
    end
  end

  // State, counter and registered outputs with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= ST_ALIVE;
      lives_q        <= INIT_LIVES;
      frame_cnt_q    <= 8'd0;
      invulnerable_q <= 1'b0;
      blink_off_q    <= 1'b0;
      life_lost_q    <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      lives_q        <= lives_d;
      frame_cnt_q    <= frame_cnt_d;
      invulnerable_q <= invulnerable_d;
      blink_off_q    <= blink_off_d;
      life_lost_q    <= life_lost_d;
      game_over_q    <= game_over_d;
    end
  end

  assign lives         = lives_q;
  assign invulnerable  = invulnerable_q;
  assign blinkOff      = blink_off_q;
  assign lifeLostPulse = life_lost_q;
  assign gameOver      = game_over_q;

endmodule

// File: tb/tb_life_manager.sv
// -----------------------------------------------------------------------------
// tb_life_manager
//   Directed self-checking bench for life_manager with default parameters
//   (3 lives, 120 invulnerable frames, blink on frame-counter bit 3).
//   Expected values are hand-computed; a small frame-counter model tracks the
//   invulnerability window to predict blinkOff and window expiry.
// -----------------------------------------------------------------------------
module tb_life_manager;

  logic       clk;
  logic       resetN;
  logic       start_of_frame;
  logic       player_hit;
  logic       extra_life;
  logic       new_game;
  logic [1:0] lives;
  logic       invulnerable;
  logic       blink_off;
  logic       life_lost_pulse;
  logic       game_over;

  int checks;
  int errors;

  // Bench model of the invulnerability window.
  int   m_cnt;
  logic m_inv;

  life_manager dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (start_of_frame),
    .playerHit     (player_hit),
    .extraLife     (extra_life),
    .newGame       (new_game),
    .lives         (lives),
    .invulnerable  (invulnerable),
    .blinkOff      (blink_off),
    .lifeLostPulse (life_lost_pulse),
    .gameOver      (game_over)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, sample 1 ns later.
  task automatic step(input logic sof, input logic hit, input logic xl, input logic ng);
    start_of_frame = sof;
    player_hit     = hit;
    extra_life     = xl;
    new_game       = ng;
    @(posedge clk);
    #1;
    start_of_frame = 1'b0;
    player_hit     = 1'b0;
    extra_life     = 1'b0;
    new_game       = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [1:0] l, input logic inv,
                           input logic blk, input logic pls, input logic go);
    check({tag, ".lives"}, {30'd0, lives}, {30'd0, l});
    check({tag, ".inv"},   {31'd0, invulnerable}, {31'd0, inv});
    check({tag, ".blink"}, {31'd0, blink_off}, {31'd0, blk});
    check({tag, ".pulse"}, {31'd0, life_lost_pulse}, {31'd0, pls});
    check({tag, ".gover"}, {31'd0, game_over}, {31'd0, go});
  endtask

  // Advance n frames, updating the window model and checking blink/inv each frame.
  task automatic run_frames(input int n, input string tag);
    logic [7:0] c8;
    logic       exp_blk;
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (m_inv) begin
        if (m_cnt == 1) begin
          m_cnt = 0;
          m_inv = 1'b0;
        end else begin
          m_cnt = m_cnt - 1;
        end
      end
      c8      = m_cnt[7:0];
      exp_blk = m_inv ? c8[3] : 1'b0;
      check({tag, ".blink"}, {31'd0, blink_off}, {31'd0, exp_blk});
      check({tag, ".inv"},   {31'd0, invulnerable}, {31'd0, m_inv});
    end
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    m_cnt  = 0;
    m_inv  = 1'b0;
    resetN         = 1'b0;
    start_of_frame = 1'b0;
    player_hit     = 1'b0;
    extra_life     = 1'b0;
    new_game       = 1'b0;
    #22;
    resetN = 1'b1;
    @(posedge clk);
    #1;

    // 1. Reset values, idle cycle
    check_all("reset", 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    // 2. Hit in ALIVE: lives 2, pulse, window starts at 120 (bit3 of 120 = 1)
    step(1'b0, 1'b1, 1'b0, 1'b0);
    m_cnt = 120; m_inv = 1'b1;
    check_all("hit1", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("hit1_pulse_off", {31'd0, life_lost_pulse}, 32'd0);
    // Hit during window is ignored
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check_all("hit_ignored", 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);

    // 3. Full window: blink follows counter bit 3, clears on exit
    run_frames(119, "win1");
    check("win1_last_inv", {31'd0, invulnerable}, 32'd1);
    run_frames(1, "win1_exit");
    check_all("win1_done", 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);

    // 4. Remaining lives down to game over
    step(1'b0, 1'b1, 1'b0, 1'b0);
    m_cnt = 120; m_inv = 1'b1;
    check_all("hit2", 2'd1, 1'b1, 1'b1, 1'b1, 1'b0);
    run_frames(120, "win2");
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check_all("hit3_fatal", 2'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_all("go_extra", 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check_all("go_hit", 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_all("newgame", 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    // 5. Saturation and extraLife in INVULN
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("sat_at_3", {30'd0, lives}, 32'd3);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    m_cnt = 120; m_inv = 1'b1;
    check("hit4_lives", {30'd0, lives}, 32'd2);
    // extraLife together with a frame: both apply (cnt 119, bit3 = 0)
    step(1'b1, 1'b0, 1'b1, 1'b0);
    m_cnt = 119;
    check_all("xl_sof", 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    // extraLife alone: saturated, counter untouched
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check_all("xl_sat_inv", 2'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    run_frames(118, "win4");
    check("win4_still_inv", {31'd0, invulnerable}, 32'd1);
    run_frames(1, "win4_exit");
    check("win4_done_inv", {31'd0, invulnerable}, 32'd0);
    // Hit + extraLife at lives 3 in ALIVE: hit wins, extra dropped
    step(1'b0, 1'b1, 1'b1, 1'b0);
    m_cnt = 120; m_inv = 1'b1;
    check_all("hit_xl", 2'd2, 1'b1, 1'b1, 1'b1, 1'b0);

    // 6. Asynchronous reset mid-window (counter at 50)
    run_frames(70, "win5");
    #2;
    resetN = 1'b0;
    #1;
    check_all("async_rst", 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    resetN = 1'b1;
    m_cnt = 0; m_inv = 1'b0;
    @(posedge clk);
    #1;
    check_all("post_rst", 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    // newGame beats playerHit
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check("pre_ng_lives", {30'd0, lives}, 32'd2);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check_all("ng_hit", 2'd3, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
